ucode_sequencer: RTL and testbench

- Fetches 32-bit microcode control words (CW) from the synchronous microcode ROM and issues them one at a time to the decoding logic.
- Takes the next-address select (S1,S0) and the return indication back from the decoder, and updates the micro-PC.
- Keeps a small call/return stack and accepts new PIM instruction entry addresses from the host.

---
 rtl/pim_ctrl_pkg.sv | 34 +++
 rtl/ucode_call_stack.sv | 58 +++++
 rtl/ucode_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ucode_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pim_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pim_ctrl_pkg
//  Purpose  : Shared types and encodings for the PIM microcode sequencer:
//             sequencer state enum, next-address select codes, CW fields.
//  Revision : 1.0 - initial release
// ============================================================================
package pim_ctrl_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } seq_state_t;

  // Next-address select encodings, {S1,S0}
  localparam logic [1:0] NEXT_INC  = 2'b00;
  localparam logic [1:0] NEXT_BR   = 2'b01;
  localparam logic [1:0] NEXT_DONE = 2'b10;
  localparam logic [1:0] NEXT_RET  = 2'b11;

  // Control-word field positions; the branch target occupies the top
  // ADDR_W bits of the CW, so its MSB is always CW_W-1.
  localparam int CALL_BIT = 16;

  // A subroutine-return indication from the decoder overrides the select.
  function automatic logic [1:0] resolve_sel(input logic [1:0] sel,
                                             input logic [1:0] ret_type);
    resolve_sel = ret_type[1] ? NEXT_RET : sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ucode_call_stack.sv
`default_nettype none
// ============================================================================
//  Module   : ucode_call_stack
//  Purpose  : LIFO of micro-PC return addresses. Pushes while full and pops
//             while empty are ignored; the caller flags those errors.
//  Revision : 1.0 - initial release
// ============================================================================
module ucode_call_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [PTR_W:0]    sp;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  top_idx;

  assign full     = (sp == (PTR_W+1)'(STACK_DEPTH));
  assign empty    = (sp == '0);
  assign wr_idx   = sp[PTR_W-1:0];
  // Index of the most recent entry; wraps naturally when sp == STACK_DEPTH.
  assign top_idx  = sp[PTR_W-1:0] - 1'b1;
  assign top_data = mem[top_idx];

  // Stack pointer: cleared per instruction, moves only on legal push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push && !full && !clear) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ucode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ucode_sequencer
//  Purpose  : Fetches microcode control words from a synchronous ROM, issues
//             them to the decoder with a valid/ready handshake and steps the
//             micro-PC (increment, branch/call, return, done).
//  Revision : 1.0 - initial release
// ============================================================================
module ucode_sequencer
  import pim_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int CW_W        = 32,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              instr_ready,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CW_W-1:0]   rom_data,
  output logic [CW_W-1:0]   cw,
  output logic              cw_valid,
  input  logic              cw_ready,
  input  logic              S0,
  input  logic              S1,
  input  logic [1:0]        ret_type,
  output logic              busy,
  output logic              stack_ovf,
  output logic              stack_unf
);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] upc, upc_nxt;
  logic [CW_W-1:0]   cw_hold;
  logic              first_issue;
  logic              do_fetch;
  logic              push, pop;
  logic              set_ovf, set_unf, clr_err;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full, stk_empty;

  // The ROM output register acts as the CW register in the first ISSUE
  // cycle; from then on the captured copy keeps cw stable under stall.
  assign cw          = first_issue ? rom_data : cw_hold;
  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign sel         = resolve_sel({S1, S0}, ret_type);

  ucode_call_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clr_err),
    .push      (push),
    .pop       (pop),
    .push_data (upc + 1'b1),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, next micro-PC and stack/error controls
  always_comb begin
    state_nxt = state;
    upc_nxt   = upc;
    do_fetch  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    clr_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (instr_valid) begin
          upc_nxt  = instr_addr;
          clr_err  = 1'b1;
          do_fetch = 1'b1;
        end
      end
      ST_FETCH: begin
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (cw_ready) begin
          if (ret_type[0]) begin
            state_nxt = ST_IDLE;
          end else begin
            case (sel)
              NEXT_INC: begin
                upc_nxt  = upc + 1'b1;
                do_fetch = 1'b1;
              end
              NEXT_BR: begin
                upc_nxt  = cw[CW_W-1 -: ADDR_W];
                do_fetch = 1'b1;
                if (cw[CALL_BIT]) begin
                  if (stk_full) set_ovf = 1'b1;
                  else          push    = 1'b1;
                end
              end
              NEXT_DONE: begin
                state_nxt = ST_IDLE;
              end
              default: begin
                do_fetch = 1'b1;
                if (stk_empty) begin
                  set_unf = 1'b1;
                  upc_nxt = '0;
                end else begin
                  pop     = 1'b1;
                  upc_nxt = stk_top;
                end
              end
            endcase
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (do_fetch) state_nxt = ST_FETCH;
  end

  // Micro-PC, ROM strobe/address and CW handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc         <= '0;
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      cw_valid    <= 1'b0;
      cw_hold     <= '0;
      first_issue <= 1'b0;
    end else begin
      upc         <= upc_nxt;
      rom_en      <= do_fetch;
      if (do_fetch) rom_addr <= upc_nxt;
      first_issue <= (state == ST_FETCH);
      if (first_issue) cw_hold <= rom_data;
      if (state == ST_FETCH) begin
        cw_valid <= 1'b1;
      end else if (state == ST_ISSUE && cw_ready) begin
        cw_valid <= 1'b0;
      end
    end
  end

  // Sticky stack error flags, cleared when a new instruction is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else if (clr_err) begin
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      if (set_ovf) stack_ovf <= 1'b1;
      if (set_unf) stack_unf <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ucode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ucode_sequencer
//  Purpose  : Directed self-checking bench for ucode_sequencer. A behavioural
//             ROM and a decoder stub (sel = cw[1:0], ret_type = cw[3:2]).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ucode_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [7:0]  instr_addr = '0;
  logic        instr_ready;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic [31:0] cw;
  logic        cw_valid;
  logic        cw_ready = 1'b1;
  logic        S0, S1;
  logic [1:0]  ret_type;
  logic        busy, stack_ovf, stack_unf;

  logic [31:0] rom [256];
  logic [7:0]  fetch_q[$];
  logic [31:0] hs_q[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  ucode_sequencer #(.ADDR_W(8), .CW_W(32), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_addr(instr_addr),
    .instr_ready(instr_ready), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .cw(cw), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .S0(S0), .S1(S1), .ret_type(ret_type), .busy(busy),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  // Synchronous ROM, data one cycle after the strobe
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  // Decoder stub
  assign {S1, S0} = cw[1:0];
  assign ret_type = cw[3:2];

  // Record every fetch address and every handshaken control word
  always @(posedge clk) begin
    if (rom_en) fetch_q.push_back(rom_addr);
    if (cw_valid && cw_ready) hs_q.push_back(cw);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_fetch();
    logic [63:0] r = '0;
    foreach (fetch_q[i]) r = {r[55:0], fetch_q[i]};
    return r;
  endfunction

  task automatic start(input logic [7:0] a);
    @(negedge clk);
    fetch_q.delete();
    hs_q.delete();
    instr_valid = 1'b1;
    instr_addr  = a;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_cw(input string tag);
    int n = 0;
    @(negedge clk);
    while (cw_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cwv"}, cw_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (rom[i]) rom[i] = 32'h0000_0002;
    rom[8'h10] = 32'h0000_1000;  // inc
    rom[8'h11] = 32'h0000_1100;  // inc
    rom[8'h12] = 32'h0000_1202;  // done
    rom[8'h20] = 32'h4001_0001;  // call 0x40
    rom[8'h40] = 32'h0000_0003;  // return (sel=11)
    rom[8'h21] = 32'h0000_0002;  // done
    rom[8'h24] = 32'h5001_0001;  // call 0x50
    rom[8'h50] = 32'h0000_0008;  // return via ret_type[1], sel=00
    rom[8'h25] = 32'h0000_0002;  // done
    rom[8'h60] = 32'h6101_0001;  // nested calls 0x60 -> 0x65
    rom[8'h61] = 32'h6201_0001;
    rom[8'h62] = 32'h6301_0001;
    rom[8'h63] = 32'h6401_0001;
    rom[8'h64] = 32'h6501_0001;  // 5th push: overflow
    rom[8'h65] = 32'h0000_0002;
    rom[8'h70] = 32'h0000_0003;  // return with empty stack
    rom[8'h00] = 32'h0000_0002;
    rom[8'hFF] = 32'h0000_0000;  // inc, wraps to 0x00
    rom[8'h80] = 32'h9000_0005;  // ret_type[0] with branch select

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cwv", cw_valid, 0);
    check("rst_romen", rom_en, 0);
    check("rst_romaddr", rom_addr, 0);
    check("rst_cw", cw, 0);
    check("rst_err", {stack_ovf, stack_unf}, 0);
    rst_n = 1'b1;

    // Linear run with latency checks
    start(8'h10);
    check("lin_romen_t1", {rom_en, rom_addr}, {1'b1, 8'h10});
    check("lin_cwv_t1", cw_valid, 0);
    check("lin_ready_t1", instr_ready, 0);
    @(posedge clk); #1;
    check("lin_cw_t2", {cw_valid, cw}, {1'b1, 32'h0000_1000});
    wait_idle("lin");
    check("lin_fetch", pack_fetch(), 64'h10_11_12);
    check("lin_nhs", hs_q.size(), 3);
    check("lin_hs2", hs_q[2], 32'h0000_1202);
    check("lin_ready", instr_ready, 1);

    // Backpressure on word 0x11
    cw_ready = 1'b0;
    start(8'h10);
    wait_cw("bp0");
    @(negedge clk); cw_ready = 1'b1;
    @(posedge clk); #1; cw_ready = 1'b0;
    wait_cw("bp1");
    for (int k = 0; k < 5; k++) begin
      check("bp_cw", {cw_valid, cw}, {1'b1, 32'h0000_1100});
      check("bp_romen", rom_en, 0);
      @(negedge clk);
    end
    cw_ready = 1'b1;
    wait_idle("bp");
    check("bp_fetch", pack_fetch(), 64'h10_11_12);
    check("bp_nhs", hs_q.size(), 3);

    // Call / return
    start(8'h20);
    wait_idle("call");
    check("call_fetch", pack_fetch(), 64'h20_40_21);
    check("call_sp", dut.u_stack.sp, 0);
    start(8'h24);
    wait_idle("rt1");
    check("rt1_fetch", pack_fetch(), 64'h24_50_25);

    // Overflow on the 5th nested call, branch still taken
    start(8'h60);
    wait_idle("ovf");
    check("ovf_fetch", pack_fetch(), 64'h60_61_62_63_64_65);
    check("ovf_flags", {stack_ovf, stack_unf}, 2'b10);
    check("ovf_sp", dut.u_stack.sp, 4);

    // Underflow: return on empty stack goes to 0x00; new instr clears ovf
    start(8'h70);
    check("unf_ovf_clr", stack_ovf, 0);
    wait_idle("unf");
    check("unf_fetch", pack_fetch(), 64'h70_00);
    check("unf_flags", {stack_ovf, stack_unf}, 2'b01);
    start(8'h12);
    wait_idle("clr");
    check("clr_flags", {stack_ovf, stack_unf}, 2'b00);

    // Micro-PC wrap
    start(8'hFF);
    wait_idle("wrap");
    check("wrap_fetch", pack_fetch(), 64'hFF_00);

    // ret_type[0] forces IDLE despite a branch select
    start(8'h80);
    wait_idle("done");
    check("done_fetch", pack_fetch(), 64'h80);
    check("done_nhs", hs_q.size(), 1);
    check("done_sp", dut.u_stack.sp, 0);

    // Asynchronous reset during ISSUE
    cw_ready = 1'b0;
    start(8'h10);
    wait_cw("ar");
    fetch_q.delete();
    hs_q.delete();
    #2 rst_n = 1'b0;
    #1;
    check("ar_cwv", cw_valid, 0);
    check("ar_rom", {rom_en, rom_addr}, 0);
    check("ar_cw", cw, 0);
    check("ar_state", {busy, instr_ready}, 2'b01);
    check("ar_err", {stack_ovf, stack_unf}, 0);
    cw_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("ar_nhs", hs_q.size(), 0);
    check("ar_nfetch", fetch_q.size(), 0);
    check("ar_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
